sample_pwm_out: RTL and testbench
=================================

SAMPLE_PWM_OUT -- requirements
Module: sample_pwm_out

Interface
REQ-001 Parameter SAMPLE_W, default 8, sample width and PWM counter width; period is 2^SAMPLE_W clocks.
REQ-002 Parameter FIFO_DEPTH, default 4, sample buffer entries; must be a power of two and at least 2.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 Port clk, input, 1, single clock; all logic on its rising edge.
REQ-005 Port rst_n, input, 1, synchronous active-low reset.
REQ-006 Port sample_in, input, SAMPLE_W, unsigned audio sample from the synthesizer wave output.
REQ-007 Port sample_valid, input, 1, sample_in is valid this cycle.
REQ-008 Port sample_ready, output, 1, block accepts a sample this cycle.
REQ-009 Port pwm_out, output, 1, registered PWM audio drive.
REQ-010 Port fifo_level, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.
REQ-011 Port underrun_cnt, output, 8, saturating count of starved PWM periods.

Function
REQ-012 A push SHALL occur on a cycle where sample_valid and sample_ready are both high.
REQ-013 sample_ready SHALL be 0 while rst_n is low and SHALL equal (fifo_level != FIFO_DEPTH) otherwise.
REQ-014 The state machine SHALL have three states: IDLE, PLAY and STARVED; it resets to IDLE.
REQ-015 In IDLE, the period counter SHALL hold at 0, duty SHALL be 0 and pwm_out SHALL be 0.
REQ-016 In IDLE with the FIFO non-empty, the block SHALL pop the head into duty, go to PLAY, and start the counter at 0 on the next cycle.
REQ-017 In PLAY and STARVED, the counter SHALL increment by 1 each clock and wrap from 2^SAMPLE_W-1 to 0.
REQ-018 pwm_out SHALL be a register loaded with (counter < duty), giving one clock of latency from the counter.
REQ-019 Duty 0 SHALL give constant low; duty 255 SHALL give high for 255 of every 256 clocks.
REQ-020 At counter==255 with the FIFO non-empty, the block SHALL pop the head into duty and set the state to PLAY (including from STARVED).
REQ-021 At counter==255 with the FIFO empty, the block SHALL go to STARVED, set duty per REQ-027/REQ-028, and increment underrun_cnt, saturating at 255.
REQ-022 Pop decisions SHALL use FIFO state before the same-cycle push; a push into an empty FIFO on the counter==255 cycle counts as an underrun.
REQ-023 A simultaneous push and pop SHALL leave fifo_level unchanged and preserve FIFO order.
REQ-024 duty SHALL change only at period boundaries or on the IDLE-to-PLAY transition, never mid-period.

Reset
REQ-025 With rst_n low at a clock edge, the block SHALL clear state to IDLE, and clear counter, duty, pwm_out, fifo_level and underrun_cnt to 0, and discard FIFO contents.
REQ-026 Reset asserted mid-period SHALL take effect at the next edge: pwm_out is 0 on the following cycle and no partial period resumes.

Configuration
REQ-027 With UNDERRUN_HOLD_EN defined, entering or staying in STARVED SHALL keep duty at the last played sample.
REQ-028 Without UNDERRUN_HOLD_EN, entering or staying in STARVED SHALL set duty to midscale 8'h80; all other behaviour is identical.

Structure
REQ-029 Package audio_pkg SHALL hold SAMPLE_W, the MIDSCALE constant 8'h80, and the state enum {IDLE, PLAY, STARVED}.
REQ-030 Buffering SHALL be a sub-module sample_fifo with push, pop, data, full, empty and level signals.
REQ-031 The FSM, period counter, duty register and underrun counter SHALL reside in sample_pwm_out.

Verification
REQ-032 The bench SHALL cover: reset, then no input for 1000 clocks -> pwm_out stays 0, state IDLE, underrun_cnt 0.
REQ-033 The bench SHALL cover: push 8'h40, then keep the FIFO fed with 8'h40 -> pwm_out high for exactly 64 of every 256 clocks, first high one cycle after the pop.
REQ-034 The bench SHALL cover: push 5 samples back-to-back with FIFO_DEPTH 4 and the FSM in IDLE -> the first sample pops immediately; sample_ready drops when level reaches 4; a held sample is accepted after the next period boundary.
REQ-035 The bench SHALL cover: play 8'hC0, then stop input for 3 periods -> underrun_cnt 3; duty 8'hC0 with UNDERRUN_HOLD_EN, otherwise 8'h80 (128 high clocks per period).
REQ-036 The bench SHALL cover: push on the exact counter==255 cycle into an empty FIFO -> underrun_cnt increments, and that sample plays in the next period.
REQ-037 The bench SHALL cover: rst_n low for 1 cycle at counter==100 with 2 samples queued -> pwm_out 0, fifo_level 0, state IDLE next cycle.

Source files
------------

// File: rtl/audio_pkg.sv
// Shared audio constants, FSM state type and small helpers for the PWM audio output path.
package audio_pkg;

    localparam int         SAMPLE_W = 8;
    localparam logic [7:0] MIDSCALE = 8'h80;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PLAY    = 2'd1,
        STARVED = 2'd2
    } state_e;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/sample_pwm_out_if.sv
// Sample stream handshake from the synthesizer into the PWM output block.
interface sample_pwm_out_if #(
    parameter int SAMPLE_W = audio_pkg::SAMPLE_W
);
    logic [SAMPLE_W-1:0] sample_in;
    logic                sample_valid;
    logic                sample_ready;

    modport master (output sample_in, output sample_valid, input sample_ready);
    modport slave  (input sample_in, input sample_valid, output sample_ready);
endinterface

// File: rtl/sample_fifo.sv
// Small power-of-two sample FIFO; head is presented combinationally, reset is synchronous active-low.
module sample_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push_i,
    input  logic [W-1:0]               wdata_i,
    input  logic                       pop_i,
    output logic [W-1:0]               rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     level_o
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   level_q, level_d;
    logic          push_ok_s, pop_ok_s;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rdata_o   = mem_q[rd_ptr_q];
    assign push_ok_s = push_i & ~full_o;
    assign pop_ok_s  = pop_i & ~empty_o;

    // Occupancy next-state; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        level_d = level_q;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_d = level_q + (AW+1)'(1);
            2'b01:   level_d = level_q - (AW+1)'(1);
            default: level_d = level_q;
        endcase
    end

    // Pointers and occupancy.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (push_ok_s) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop_ok_s)  rd_ptr_q <= rd_ptr_q + AW'(1);
            level_q <= level_d;
        end
    end

    // Storage; contents are meaningless once the pointers are cleared.
    always_ff @(posedge clk) begin
        if (push_ok_s) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/sample_pwm_out.sv
// Buffered sample-to-PWM audio output with starvation tracking.
// Optional macro UNDERRUN_HOLD_EN: hold the last played duty while starved instead of midscale.
module sample_pwm_out #(
    parameter int SAMPLE_W   = audio_pkg::SAMPLE_W,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    sample_pwm_out_if.slave               s_if,
    output logic                          pwm_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic [7:0]                    underrun_cnt
);
    import audio_pkg::*;

    localparam logic [SAMPLE_W-1:0] CNT_MAX = '1;
    localparam logic [SAMPLE_W-1:0] MID_L   = (SAMPLE_W == 8) ? SAMPLE_W'(MIDSCALE)
                                                              : {1'b1, {(SAMPLE_W-1){1'b0}}};

    state_e              state_q, state_d;
    logic [SAMPLE_W-1:0] cnt_q, cnt_d;
    logic [SAMPLE_W-1:0] duty_q, duty_d;
    logic [7:0]          under_q, under_d;
    logic                pwm_q, pwm_d;

    logic                push_s, pop_s, full_s, empty_s;
    logic [SAMPLE_W-1:0] head_s, starve_duty_s;

    assign s_if.sample_ready = rst_n & ~full_s;
    assign push_s            = s_if.sample_valid & s_if.sample_ready;
    assign pwm_out           = pwm_q;
    assign underrun_cnt      = under_q;

`ifdef UNDERRUN_HOLD_EN
    assign starve_duty_s = duty_q;
`else
    assign starve_duty_s = MID_L;
`endif

    sample_fifo #(
        .W     (SAMPLE_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_s),
        .wdata_i (s_if.sample_in),
        .pop_i   (pop_s),
        .rdata_o (head_s),
        .full_o  (full_s),
        .empty_o (empty_s),
        .level_o (fifo_level)
    );

    // Player FSM: decisions see FIFO state before any same-cycle push.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        duty_d  = duty_q;
        under_d = under_q;
        pop_s   = 1'b0;
        pwm_d   = (cnt_q < duty_q);
        case (state_q)
            IDLE: begin
                cnt_d  = '0;
                duty_d = '0;
                if (!empty_s) begin
                    pop_s   = 1'b1;
                    duty_d  = head_s;
                    state_d = PLAY;
                end else begin
                    state_d = IDLE;
                end
            end
            PLAY, STARVED: begin
                cnt_d = cnt_q + SAMPLE_W'(1);
                if (cnt_q == CNT_MAX) begin
                    if (!empty_s) begin
                        pop_s   = 1'b1;
                        duty_d  = head_s;
                        state_d = PLAY;
                    end else begin
                        duty_d  = starve_duty_s;
                        under_d = sat_inc8(under_q);
                        state_d = STARVED;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                duty_d  = '0;
            end
        endcase
    end

    // State, counter, duty, output and underrun registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            duty_q  <= '0;
            under_q <= 8'd0;
            pwm_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            duty_q  <= duty_d;
            under_q <= under_d;
            pwm_q   <= pwm_d;
        end
    end

endmodule

// File: tb/tb_sample_pwm_out.sv
// Scoreboard bench for sample_pwm_out: stimulus queues expectations, a negedge monitor checks them.
module tb_sample_pwm_out;
    import audio_pkg::*;

    localparam int K_PWM = 0, K_LVL = 1, K_UND = 2, K_RDY = 3, K_ST = 4, K_WIN = 5;
`ifdef UNDERRUN_HOLD_EN
    localparam int STARVE_HIGH = 192;
`else
    localparam int STARVE_HIGH = 128;
`endif

    typedef struct {
        int    kind;
        int    exp;
        string name;
    } exp_t;

    exp_t       exp_q[$];
    int         total = 0;
    int         bad   = 0;
    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       pwm_out;
    logic [2:0] fifo_level;
    logic [7:0] underrun_cnt;
    bit         hist [256];
    int         wptr    = 0;
    int         win_cnt = 0;

    sample_pwm_out_if #(.SAMPLE_W(8)) s_if ();

    sample_pwm_out #(.SAMPLE_W(8), .FIFO_DEPTH(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .s_if         (s_if),
        .pwm_out      (pwm_out),
        .fifo_level   (fifo_level),
        .underrun_cnt (underrun_cnt)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic expect_v(input int kind, input int v, input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = v;
        e.name = name;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic v, input logic [7:0] d);
        s_if.sample_valid = v;
        s_if.sample_in    = d;
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0;
        drive(1'b0, 8'h00);
        ticks(2);
        expect_v(K_RDY, 0, {tag, "_rst_ready"});
        expect_v(K_PWM, 0, {tag, "_rst_pwm"});
        expect_v(K_LVL, 0, {tag, "_rst_level"});
        expect_v(K_UND, 0, {tag, "_rst_underrun"});
        expect_v(K_ST, int'(IDLE), {tag, "_rst_state"});
        #6;
        rst_n = 1'b1;
    endtask

    // Monitor: tracks highs over the last 256 clocks and drains the expectation queue.
    initial begin
        exp_t e;
        int   act;
        for (int i = 0; i < 256; i++) hist[i] = 1'b0;
        forever begin
            @(negedge clk);
            win_cnt    = win_cnt + int'(pwm_out) - int'(hist[wptr]);
            hist[wptr] = pwm_out;
            wptr       = (wptr + 1) % 256;
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                case (e.kind)
                    K_PWM:   act = int'(pwm_out);
                    K_LVL:   act = int'(fifo_level);
                    K_UND:   act = int'(underrun_cnt);
                    K_RDY:   act = int'(s_if.sample_ready);
                    K_ST:    act = int'(dut.state_q);
                    default: act = win_cnt;
                endcase
                total++;
                if (act != e.exp) begin
                    bad++;
                    $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
                end
            end
        end
    end

    initial begin
        drive(1'b0, 8'h00);

        // Idle after reset with no input.
        do_reset("idle");
        ticks(1000);
        expect_v(K_PWM, 0, "idle_pwm");
        expect_v(K_ST, int'(IDLE), "idle_state");
        expect_v(K_UND, 0, "idle_underrun");
        expect_v(K_WIN, 0, "idle_window");
        expect_v(K_LVL, 0, "idle_level");

        // Continuous 8'h40 stream: 64 highs per 256 clocks.
        do_reset("q40");
        drive(1'b1, 8'h40);
        tick();
        expect_v(K_LVL, 1, "q40_push_level");
        expect_v(K_PWM, 0, "q40_push_pwm");
        tick();
        expect_v(K_ST, int'(PLAY), "q40_pop_state");
        expect_v(K_PWM, 0, "q40_pop_pwm");
        expect_v(K_LVL, 1, "q40_pop_level");
        tick();
        expect_v(K_PWM, 1, "q40_first_high");
        ticks(63);
        expect_v(K_PWM, 1, "q40_last_high");
        tick();
        expect_v(K_PWM, 0, "q40_first_low");
        ticks(703);
        expect_v(K_WIN, 64, "q40_window");
        expect_v(K_LVL, 3, "q40_boundary_level");
        expect_v(K_UND, 0, "q40_underrun");
        drive(1'b0, 8'h00);

        // Five back-to-back samples into a depth-4 FIFO.
        do_reset("burst");
        drive(1'b1, 8'd10);
        tick();
        expect_v(K_LVL, 1, "burst_l1");
        drive(1'b1, 8'd20);
        tick();
        expect_v(K_LVL, 1, "burst_pop_level");
        expect_v(K_ST, int'(PLAY), "burst_state");
        drive(1'b1, 8'd30);
        tick();
        drive(1'b1, 8'd40);
        tick();
        drive(1'b1, 8'd50);
        tick();
        expect_v(K_LVL, 4, "burst_full_level");
        expect_v(K_RDY, 0, "burst_full_ready");
        ticks(252);
        expect_v(K_RDY, 0, "burst_held_ready");
        expect_v(K_LVL, 4, "burst_held_level");
        tick();
        expect_v(K_LVL, 3, "burst_boundary_level");
        expect_v(K_RDY, 1, "burst_boundary_ready");
        tick();
        expect_v(K_LVL, 4, "burst_accept_level");
        drive(1'b0, 8'h00);

        // Play 8'hC0 then starve for three periods, then push on the last counter cycle.
        do_reset("starve");
        drive(1'b1, 8'hC0);
        tick();
        drive(1'b0, 8'h00);
        ticks(256);
        expect_v(K_UND, 0, "starve_before");
        tick();
        expect_v(K_UND, 1, "starve_u1");
        expect_v(K_WIN, 192, "starve_c0_window");
        expect_v(K_ST, int'(STARVED), "starve_state");
        ticks(256);
        expect_v(K_UND, 2, "starve_u2");
        expect_v(K_WIN, STARVE_HIGH, "starve_duty_p2");
        ticks(256);
        expect_v(K_UND, 3, "starve_u3");
        expect_v(K_WIN, STARVE_HIGH, "starve_duty_p3");
        ticks(255);
        drive(1'b1, 8'h20);
        tick();
        drive(1'b0, 8'h00);
        expect_v(K_UND, 4, "edge_push_underrun");
        expect_v(K_LVL, 1, "edge_push_level");
        expect_v(K_ST, int'(STARVED), "edge_push_state");
        ticks(256);
        expect_v(K_ST, int'(PLAY), "edge_play_state");
        expect_v(K_LVL, 0, "edge_play_level");
        expect_v(K_UND, 4, "edge_play_underrun");
        ticks(256);
        expect_v(K_WIN, 32, "edge_played_window");
        expect_v(K_UND, 5, "edge_next_underrun");

        // Reset pulse mid-period with two samples queued.
        do_reset("midrst");
        drive(1'b1, 8'h90);
        tick();
        drive(1'b1, 8'h11);
        tick();
        drive(1'b1, 8'h22);
        tick();
        drive(1'b0, 8'h00);
        ticks(99);
        expect_v(K_LVL, 2, "midrst_pre_level");
        expect_v(K_PWM, 1, "midrst_pre_pwm");
        rst_n = 1'b0;
        tick();
        expect_v(K_PWM, 0, "midrst_pwm");
        expect_v(K_LVL, 0, "midrst_level");
        expect_v(K_ST, int'(IDLE), "midrst_state");
        expect_v(K_UND, 0, "midrst_underrun");
        expect_v(K_RDY, 0, "midrst_ready");
        #6;
        rst_n = 1'b1;
        ticks(3);
        expect_v(K_RDY, 1, "midrst_after_ready");
        expect_v(K_ST, int'(IDLE), "midrst_after_state");
        expect_v(K_PWM, 0, "midrst_after_pwm");

        for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
        #1;
        if (exp_q.size() > 0) begin
            bad++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
